bram_port_arbiter: RTL
======================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, address width of BRAM port A and both requesters.
REQ-002 Parameter: DATA_W, 16, data width.
REQ-003 Parameter: MAX_BURST, 8, max consecutive grants to one owner while the other requests; legal range 1..255.
REQ-004 Port: clk  input  1  single clock; all logic is on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Ports, requester n (n=0 CPU memory controller, n=1 secondary master): mN_req input 1; mN_we input 1; mN_addr input ADDR_W; mN_wdata input DATA_W; mN_gnt output 1; mN_rvalid output 1; mN_rdata output DATA_W.
REQ-007 Ports, BRAM side: bram_addra output ADDR_W; bram_dina output DATA_W; bram_wea output 1; bram_douta input DATA_W (1-cycle read latency).

Function
REQ-008 Transfer accepted in cycle N iff mN_req && mN_gnt in N; requester holds req/we/addr/wdata stable until accepted.
REQ-009 At most one mN_gnt high per cycle; a grant is never given without the matching mN_req.
REQ-010 bram_addra/bram_dina/bram_wea combinationally follow the granted requester; with no grant: bram_wea=0, bram_addra/bram_dina=0.
REQ-011 Read accepted in N (we=0): mN_rvalid=1 in N+1 only, mN_rdata=bram_douta in N+1; mN_rdata=0 whenever mN_rvalid=0.
REQ-012 Write accepted in N: bram_wea=1 in N only; no rvalid pulse.
REQ-013 FSM states IDLE, OWN0, OWN1; state is registered, grant is decoded from next-owner logic in the same cycle as req (zero-cycle grant latency).
REQ-014 IDLE: one requester -> grant it, go OWNn; both -> grant per arbitration policy (REQ-020), go OWNn; none -> stay IDLE.
REQ-015 OWNn, mN_req=1, other not requesting -> keep granting n indefinitely; burst counter holds at 0.
REQ-016 OWNn, both requesting -> grant n while burst counter < MAX_BURST, incrementing per accepted transfer; on reaching MAX_BURST, next cycle grants the other requester, switches state, clears counter.
REQ-017 OWNn, mN_req=0 -> same cycle, grant other if requesting (switch state) else go IDLE; counter cleared.
REQ-018 Burst counter is 8 bits, saturating; never wraps.
REQ-019 A pending rvalid (read accepted in the previous cycle) is delivered regardless of an ownership change in the current cycle.
REQ-020 Tie-break when both request from IDLE: per Configuration section.

Reset
REQ-021 rst low asynchronously forces: state=IDLE, burst counter=0, last-owner=1, pending-read flags=0; all mN_gnt, mN_rvalid, bram_wea=0; mN_rdata=0.
REQ-022 Reset mid-transfer discards any pending read; no rvalid emitted after release for pre-reset reads.
REQ-023 First grant after reset release goes no earlier than the first rising edge with rst high.

Configuration
REQ-024 Macro BRAM_ARB_ROUND_ROBIN_EN defined: IDLE tie goes to the requester that was not last owner (last-owner reset value 1, so m0 wins first tie).
REQ-025 Macro BRAM_ARB_ROUND_ROBIN_EN undefined: IDLE tie always goes to m0 (fixed priority); REQ-016 burst limiting still applies.

Verification
REQ-026 After reset, m0 read addr 0x0010 alone, BRAM[0x0010]=0xBEEF -> m0_gnt same cycle, m0_rvalid=1 with m0_rdata=0xBEEF next cycle, m1 signals all 0.
REQ-027 m0 write 0x0020<-0x1234 then m1 read 0x0020 next cycle -> bram_wea=1 one cycle, m1_rdata=0x1234 one cycle after m1 grant.
REQ-028 Both hold req continuously, MAX_BURST=8 -> m0 granted exactly 8 consecutive cycles, then m1 8, alternating; never both gnt.
REQ-029 Both request simultaneously from IDLE twice (with idle gap) -> macro defined: m0 then m1 wins; macro undefined: m0 both times.
REQ-030 rst driven low the cycle after m1 read accepted -> m1_rvalid stays 0, state IDLE, all outputs 0 immediately (asynchronous).
REQ-031 m0 owns, drops req same cycle m1 raises -> m1_gnt that cycle, counter restarts at 0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of BRAM port A, with zero-cycle grant and a bounded burst under contention.
// Optional feature: define BRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break from IDLE (default: m0 fixed priority).
module bram_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    output logic              bram_wea,
    input  logic [DATA_W-1:0] bram_douta
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state_r;
    state_t     state_n;
    logic [7:0] burst_r;
    logic [7:0] burst_n;
    logic       pend0_r;
    logic       pend1_r;
    logic       run_r;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       tie_gnt1_s;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    logic       last_owner_r;

    // Only IDLE ties update the last owner, so each new contended session alternates its winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_r <= 1'b1;
        end else if (state_r == IDLE && run_r && m0_req && m1_req) begin
            last_owner_r <= gnt1_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    assign tie_gnt1_s = ~last_owner_r;
`else
    assign tie_gnt1_s = 1'b0;
`endif

    // Next-owner decode: grants are issued in the same cycle as the request.
    // A contended grant counts toward the burst, so the grant that switches owners opens the new burst at one.
    always_comb begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        state_n = state_r;
        burst_n = burst_r;
        if (!run_r) begin
            state_n = IDLE;
            burst_n = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        if (tie_gnt1_s) begin
                            gnt1_s  = 1'b1;
                            state_n = OWN1;
                        end else begin
                            gnt0_s  = 1'b1;
                            state_n = OWN0;
                        end
                        burst_n = 8'd1;
                    end else if (m0_req) begin
                        gnt0_s  = 1'b1;
                        state_n = OWN0;
                        burst_n = 8'd0;
                    end else if (m1_req) begin
                        gnt1_s  = 1'b1;
                        state_n = OWN1;
                        burst_n = 8'd0;
                    end else begin
                        state_n = IDLE;
                        burst_n = 8'd0;
                    end
                end
                OWN0: begin
                    if (m0_req && m1_req) begin
                        if (burst_r >= BURST_LIM) begin
                            gnt1_s  = 1'b1;
                            state_n = OWN1;
                            burst_n = 8'd1;
                        end else begin
                            gnt0_s  = 1'b1;
                            burst_n = sat_inc(burst_r);
                        end
                    end else if (m0_req) begin
                        gnt0_s  = 1'b1;
                        burst_n = 8'd0;
                    end else if (m1_req) begin
                        gnt1_s  = 1'b1;
                        state_n = OWN1;
                        burst_n = 8'd0;
                    end else begin
                        state_n = IDLE;
                        burst_n = 8'd0;
                    end
                end
                OWN1: begin
                    if (m0_req && m1_req) begin
                        if (burst_r >= BURST_LIM) begin
                            gnt0_s  = 1'b1;
                            state_n = OWN0;
                            burst_n = 8'd1;
                        end else begin
                            gnt1_s  = 1'b1;
                            burst_n = sat_inc(burst_r);
                        end
                    end else if (m1_req) begin
                        gnt1_s  = 1'b1;
                        burst_n = 8'd0;
                    end else if (m0_req) begin
                        gnt0_s  = 1'b1;
                        state_n = OWN0;
                        burst_n = 8'd0;
                    end else begin
                        state_n = IDLE;
                        burst_n = 8'd0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    burst_n = 8'd0;
                end
            endcase
        end
    end

    // State, burst count and read-pending flags; run_r holds off grants until the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            burst_r <= 8'd0;
            pend0_r <= 1'b0;
            pend1_r <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            burst_r <= burst_n;
            pend0_r <= gnt0_s & ~m0_we;
            pend1_r <= gnt1_s & ~m1_we;
            run_r   <= 1'b1;
        end
    end

    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign m0_rvalid = pend0_r;
    assign m1_rvalid = pend1_r;

    // Read data is steered from the BRAM only in the cycle its read pulse is pending.
    always_comb begin
        m0_rdata = '0;
        m1_rdata = '0;
        if (pend0_r) begin
            m0_rdata = bram_douta;
        end else begin
            m0_rdata = '0;
        end
        if (pend1_r) begin
            m1_rdata = bram_douta;
        end else begin
            m1_rdata = '0;
        end
    end

    // BRAM port A mux follows the current grant.
    always_comb begin
        bram_addra = '0;
        bram_dina  = '0;
        bram_wea   = 1'b0;
        if (gnt0_s) begin
            bram_addra = m0_addr;
            bram_dina  = m0_wdata;
            bram_wea   = m0_we;
        end else if (gnt1_s) begin
            bram_addra = m1_addr;
            bram_dina  = m1_wdata;
            bram_wea   = m1_we;
        end else begin
            bram_addra = '0;
            bram_dina  = '0;
            bram_wea   = 1'b0;
        end
    end

endmodule
